adder_rr_scheduler: RTL

Round-robin scheduler that shares one `n_bit_pg_carry_ripple` adder instance among R requesters. It accepts one request at a time over a valid/ready handshake, registers the operands, and registers the adder result. It then returns the sum, carry-out, signed-overflow flag and requester ID over a valid/ready response port. It sits between the arithmetic clients and the single shared N-bit carry-ripple datapath.

---
 rtl/adder_rr_scheduler.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/adder_rr_scheduler.sv
// Purpose: round-robin arbiter feeding one shared N-bit carry-ripple adder, one request in flight.
// Latency: request handshake at cycle t -> CALC at t+1 -> rsp_valid at t+2 (3-cycle turnaround).
// Backpressure: rsp_ready low holds RESP with stable outputs; no request is accepted outside IDLE.

module n_bit_pg_carry_ripple #(
   parameter int N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);
   logic [N-1:0] p;
   logic [N-1:0] g;

   assign p = a ^ b;
   assign g = a & b;

   // Ripple the carry through the propagate/generate chain, LSB first.
   always_comb begin
      logic c;
      c   = cin;
      sum = '0;
      for (int i = 0; i < N; i++) begin
         sum[i] = p[i] ^ c;
         c      = g[i] | (p[i] & c);
      end
      cout = c;
   end
endmodule

module adder_rr_scheduler #(
   parameter int N   = 32,
   parameter int R   = 4,
   parameter int IDW = $clog2(R)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [R-1:0]   req_valid,
   output logic [R-1:0]   req_ready,
   input  logic [R*N-1:0] req_a,
   input  logic [R*N-1:0] req_b,
   input  logic [R-1:0]   req_cin,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic [N-1:0]   rsp_sum,
   output logic           rsp_cout,
   output logic           rsp_ovf,
   output logic [IDW-1:0] rsp_id
);
   typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

   state_t           state_q, state_d;
   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [N-1:0]     a_q, a_d;
   logic [N-1:0]     b_q, b_d;
   logic             cin_q, cin_d;
   logic [IDW-1:0]   gnt_q, gnt_d;
   logic [N-1:0]     rsp_sum_q, rsp_sum_d;
   logic             rsp_cout_q, rsp_cout_d;
   logic             rsp_ovf_q, rsp_ovf_d;
   logic [IDW-1:0]   rsp_id_q, rsp_id_d;

   logic [IDW-1:0]   gnt;
   logic             found;
   logic [N-1:0]     add_sum;
   logic             add_cout;

   n_bit_pg_carry_ripple #(.N(N)) u_adder (
      .a    (a_q),
      .b    (b_q),
      .cin  (cin_q),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // First valid requester at or after ptr, wrapping R-1 -> 0.
   always_comb begin
      int idx;
      gnt   = '0;
      found = 1'b0;
      for (int k = 0; k < R; k++) begin
         idx = (int'(ptr_q) + k) % R;
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            gnt   = IDW'(idx);
         end
      end
   end

   // Next-state, operand capture and result registration.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      a_d        = a_q;
      b_d        = b_q;
      cin_d      = cin_q;
      gnt_d      = gnt_q;
      rsp_sum_d  = rsp_sum_q;
      rsp_cout_d = rsp_cout_q;
      rsp_ovf_d  = rsp_ovf_q;
      rsp_id_d   = rsp_id_q;
      req_ready  = '0;
      case (state_q)
         IDLE: begin
            // Ready is held low while reset is asserted so outputs read as reset values.
            if (found && !reset) begin
               req_ready = {{(R-1){1'b0}}, 1'b1} << gnt;
               a_d       = req_a[int'(gnt)*N +: N];
               b_d       = req_b[int'(gnt)*N +: N];
               cin_d     = req_cin[gnt];
               gnt_d     = gnt;
               state_d   = CALC;
            end
         end
         CALC: begin
            rsp_sum_d  = add_sum;
            rsp_cout_d = add_cout;
            rsp_ovf_d  = (a_q[N-1] ~^ b_q[N-1]) & (a_q[N-1] ^ add_sum[N-1]);
            rsp_id_d   = gnt_q;
            state_d    = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               ptr_d   = IDW'((int'(rsp_id_q) + 1) % R);
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         cin_q      <= 1'b0;
         gnt_q      <= '0;
         rsp_sum_q  <= '0;
         rsp_cout_q <= 1'b0;
         rsp_ovf_q  <= 1'b0;
         rsp_id_q   <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         a_q        <= a_d;
         b_q        <= b_d;
         cin_q      <= cin_d;
         gnt_q      <= gnt_d;
         rsp_sum_q  <= rsp_sum_d;
         rsp_cout_q <= rsp_cout_d;
         rsp_ovf_q  <= rsp_ovf_d;
         rsp_id_q   <= rsp_id_d;
      end
   end

   assign rsp_valid = (state_q == RESP);
   assign rsp_sum   = rsp_sum_q;
   assign rsp_cout  = rsp_cout_q;
   assign rsp_ovf   = rsp_ovf_q;
   assign rsp_id    = rsp_id_q;
endmodule
